// File: rtl/led_pio_sequencer.sv
// led_pio_sequencer: Avalon-MM LED pattern sequencer that drives a PIO s1 slave as its only writer
module led_pio_sequencer #(
    parameter int LED_WIDTH      = 6,
    parameter int PERIOD_WIDTH   = 24,
    parameter int DEFAULT_PERIOD = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cfg_address,
    input  logic        cfg_chipselect,
    input  logic        cfg_write_n,
    input  logic [31:0] cfg_writedata,
    output logic [31:0] cfg_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, ISSUE} state_t;
    state_t state, state_d;
    logic [2:0] ctrl, ctrl_d;
    logic [PERIOD_WIDTH-1:0] period, period_d, timer, timer_d, period_eff;
    logic [LED_WIDTH-1:0] pattern, pattern_d, cur, cur_d, led, led_d;
    logic phase, phase_d, pending, pending_d, req, go;
    logic wr, w_ctrl, w_period, w_pattern, w_direct, en, en_d, rise, term;
    logic unused_bits;
    assign unused_bits = &{1'b0, cfg_writedata[31:PERIOD_WIDTH]};
    assign wr         = cfg_chipselect & ~cfg_write_n;
    assign w_ctrl     = wr & (cfg_address == 2'd0);
    assign w_period   = wr & (cfg_address == 2'd1);
    assign w_pattern  = wr & (cfg_address == 2'd2);
    assign w_direct   = wr & (cfg_address == 2'd3);
    assign en         = ctrl[0];
    assign en_d       = w_ctrl ? cfg_writedata[0] : en;
    assign rise       = w_ctrl & cfg_writedata[0] & ~en;
    assign period_eff = (period == '0) ? PERIOD_WIDTH'(1) : period;
    // a shrunken PERIOD at or below the running timer terminates on the next compare
    assign term       = en & en_d & (timer >= period_eff - PERIOD_WIDTH'(1));
    assign pio_address    = 2'd0;
    assign pio_chipselect = (state == ISSUE);
    assign pio_write_n    = ~(state == ISSUE);
    assign pio_writedata  = 32'(led);
    assign busy           = en | pending | (state == ISSUE);
    // zero-wait register readback; cur is visible through the DIRECT address
    always_comb begin
        cfg_readdata = (cfg_address == 2'd0) ? 32'(ctrl) :
                       (cfg_address == 2'd1) ? 32'(period) :
                       (cfg_address == 2'd2) ? 32'(pattern) : 32'(cur);
    end
    // next-state and update selection: DIRECT > enable rise > static PATTERN > timed update
    always_comb begin
        ctrl_d    = w_ctrl ? cfg_writedata[2:0] : ctrl;
        period_d  = w_period ? cfg_writedata[PERIOD_WIDTH-1:0] : period;
        pattern_d = w_pattern ? cfg_writedata[LED_WIDTH-1:0] : pattern;
        cur_d     = cur;
        phase_d   = phase;
        timer_d   = en_d ? timer + PERIOD_WIDTH'(1) : '0;
        req       = 1'b0;
        if (w_direct) begin
            cur_d   = cfg_writedata[LED_WIDTH-1:0];
            timer_d = '0;
            req     = 1'b1;
        end else if (rise) begin
            cur_d   = pattern;
            phase_d = 1'b1;
            timer_d = '0;
            req     = 1'b1;
        end else if (w_pattern && en && ctrl[2:1] == 2'b00) begin
            cur_d = cfg_writedata[LED_WIDTH-1:0];
            req   = 1'b1;
        end else if (term) begin
            timer_d = '0;
            req     = (ctrl[2:1] != 2'b00);
            phase_d = (ctrl[2:1] == 2'b10) ? ~phase : phase;
            cur_d   = (ctrl[2:1] == 2'b01) ? ((cur == '0) ? LED_WIDTH'(1) : {cur[LED_WIDTH-2:0], cur[LED_WIDTH-1]}) :
                      (ctrl[2:1] == 2'b10) ? (~phase ? pattern : '0) :
                      (ctrl[2:1] == 2'b11) ? cur + LED_WIDTH'(1) : cur;
        end
        go        = (req | pending) & (state != ISSUE);
        pending_d = (req | pending) & (state == ISSUE);
        led_d     = go ? cur_d : led;
        state_d   = go ? ISSUE : (en_d ? RUN : IDLE);
    end
    // state and register file; reset drops any in-flight PIO write
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ctrl    <= '0;
            period  <= PERIOD_WIDTH'(DEFAULT_PERIOD);
            pattern <= '0;
            cur     <= '0;
            led     <= '0;
            phase   <= 1'b0;
            timer   <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_d;
            ctrl    <= ctrl_d;
            period  <= period_d;
            pattern <= pattern_d;
            cur     <= cur_d;
            led     <= led_d;
            phase   <= phase_d;
            timer   <= timer_d;
            pending <= pending_d;
        end
    end
endmodule

// File: tb/tb_led_pio_sequencer.sv
// tb_led_pio_sequencer: directed self-checking bench for led_pio_sequencer
module tb_led_pio_sequencer;
    logic clk = 0, reset = 1;
    logic [1:0] cfg_address = 0;
    logic cfg_chipselect = 0, cfg_write_n = 1;
    logic [31:0] cfg_writedata = 0, cfg_readdata, pio_writedata;
    logic [1:0] pio_address;
    logic pio_chipselect, pio_write_n, busy;
    int checks = 0, errors = 0, cyc = 0, t0, n0;
    int lc[$];
    logic [5:0] lv[$];
    logic prev_cs = 0, b2b = 0;

    led_pio_sequencer dut (
        .clk(clk), .reset(reset), .cfg_address(cfg_address), .cfg_chipselect(cfg_chipselect),
        .cfg_write_n(cfg_write_n), .cfg_writedata(cfg_writedata), .cfg_readdata(cfg_readdata),
        .pio_address(pio_address), .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
        .pio_writedata(pio_writedata), .busy(busy)
    );

    always #5 clk = ~clk;

    // log every PIO write pulse with its cycle number
    always @(negedge clk) begin
        cyc++;
        if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
            lc.push_back(cyc);
            lv.push_back(pio_writedata[5:0]);
            if (prev_cs) b2b = 1;
            prev_cs = 1;
        end else prev_cs = 0;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
        cfg_address = a; cfg_writedata = d; cfg_chipselect = 1; cfg_write_n = 0;
        @(posedge clk); #1;
        cfg_chipselect = 0; cfg_write_n = 1;
    endtask

    task automatic wait_writes(input int n);
        for (int k = 0; k < 300 && lv.size() < n; k++) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1; idle(3); reset = 0;
        n0 = lv.size();
        idle(100);
        cfg_address = 1; @(negedge clk);
        checks++; if (pio_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got %b want 0", pio_chipselect); end
        checks++; if (pio_write_n !== 1'b1) begin errors++; $display("FAIL reset_wn got %b want 1", pio_write_n); end
        checks++; if (pio_address !== 2'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", pio_address); end
        checks++; if (pio_writedata !== 32'd0) begin errors++; $display("FAIL reset_wd got %h want 0", pio_writedata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (cfg_readdata !== 32'd5000000) begin errors++; $display("FAIL reset_period got %0d want 5000000", cfg_readdata); end
        checks++; if (lv.size() != n0) begin errors++; $display("FAIL idle_writes got %0d want 0", lv.size() - n0); end
        idle(1);
    endtask

    task automatic test_walk;
        logic [5:0] ev[7] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
        int et[7] = '{1, 5, 9, 13, 17, 21, 25};
        cfg_wr(1, 4); cfg_wr(2, 1);
        n0 = lv.size();
        cfg_wr(0, 3); t0 = cyc;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL walk_busy got %b want 1", busy); end
        wait_writes(n0 + 7);
        checks++;
        if (lv.size() < n0 + 7) begin errors++; $display("FAIL walk_timeout got %0d want 7 writes", lv.size() - n0); end
        else for (int i = 0; i < 7; i++) begin
            if (i > 0) checks++;
            if (lv[n0+i] !== ev[i] || lc[n0+i] - t0 != et[i]) begin
                errors++; $display("FAIL walk[%0d] got %h@%0d want %h@%0d", i, lv[n0+i], lc[n0+i] - t0, ev[i], et[i]);
            end
        end
        cfg_wr(0, 0); idle(10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL walk_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_blink;
        logic [5:0] ev[4] = '{6'h2A, 6'h00, 6'h2A, 6'h00};
        int et[4] = '{1, 4, 7, 10};
        cfg_wr(1, 3); cfg_wr(2, 32'h2A);
        n0 = lv.size();
        cfg_wr(0, 5); t0 = cyc;
        wait_writes(n0 + 4);
        checks++;
        if (lv.size() < n0 + 4) begin errors++; $display("FAIL blink_timeout got %0d want 4 writes", lv.size() - n0); end
        else for (int i = 0; i < 4; i++) begin
            if (i > 0) checks++;
            if (lv[n0+i] !== ev[i] || lc[n0+i] - t0 != et[i]) begin
                errors++; $display("FAIL blink[%0d] got %h@%0d want %h@%0d", i, lv[n0+i], lc[n0+i] - t0, ev[i], et[i]);
            end
        end
        cfg_wr(0, 0); idle(10);
    endtask

    task automatic test_count_wrap;
        logic [5:0] ev[3] = '{6'h3F, 6'h00, 6'h01};
        int et[3] = '{1, 5, 9};
        cfg_wr(1, 4); cfg_wr(2, 32'h3F);
        n0 = lv.size();
        cfg_wr(0, 7); t0 = cyc;
        wait_writes(n0 + 3);
        checks++;
        if (lv.size() < n0 + 3) begin errors++; $display("FAIL count_timeout got %0d want 3 writes", lv.size() - n0); end
        else for (int i = 0; i < 3; i++) begin
            if (i > 0) checks++;
            if (lv[n0+i] !== ev[i] || lc[n0+i] - t0 != et[i]) begin
                errors++; $display("FAIL count[%0d] got %h@%0d want %h@%0d", i, lv[n0+i], lc[n0+i] - t0, ev[i], et[i]);
            end
        end
        cfg_wr(0, 0); idle(10);
    endtask

    task automatic test_direct_at_tc;
        logic [5:0] ev[4] = '{6'h01, 6'h15, 6'h2A, 6'h15};
        int et[4] = '{1, 6, 11, 16};
        cfg_wr(1, 5); cfg_wr(2, 1);
        n0 = lv.size();
        cfg_wr(0, 3); t0 = cyc;
        idle(4);
        cfg_wr(3, 32'h15);
        wait_writes(n0 + 4);
        checks++;
        if (lv.size() < n0 + 4) begin errors++; $display("FAIL dtc_timeout got %0d want 4 writes", lv.size() - n0); end
        else for (int i = 0; i < 4; i++) begin
            if (i > 0) checks++;
            if (lv[n0+i] !== ev[i] || lc[n0+i] - t0 != et[i]) begin
                errors++; $display("FAIL dtc[%0d] got %h@%0d want %h@%0d", i, lv[n0+i], lc[n0+i] - t0, ev[i], et[i]);
            end
        end
        cfg_wr(0, 0); idle(10);
    endtask

    task automatic test_direct_restart;
        logic [5:0] ev[3] = '{6'h01, 6'h08, 6'h10};
        int et[3] = '{1, 4, 9};
        n0 = lv.size();
        cfg_wr(0, 3); t0 = cyc;
        idle(2);
        cfg_wr(3, 32'h08);
        wait_writes(n0 + 3);
        checks++;
        if (lv.size() < n0 + 3) begin errors++; $display("FAIL drs_timeout got %0d want 3 writes", lv.size() - n0); end
        else for (int i = 0; i < 3; i++) begin
            if (i > 0) checks++;
            if (lv[n0+i] !== ev[i] || lc[n0+i] - t0 != et[i]) begin
                errors++; $display("FAIL drs[%0d] got %h@%0d want %h@%0d", i, lv[n0+i], lc[n0+i] - t0, ev[i], et[i]);
            end
        end
        cfg_wr(0, 0); idle(10);
    endtask

    task automatic test_back_to_back;
        logic [5:0] ev[3] = '{6'h01, 6'h07, 6'h0E};
        int et[3] = '{1, 3, 7};
        n0 = lv.size();
        cfg_wr(0, 3); t0 = cyc;
        cfg_wr(3, 32'h07);
        wait_writes(n0 + 3);
        checks++;
        if (lv.size() < n0 + 3) begin errors++; $display("FAIL b2b_timeout got %0d want 3 writes", lv.size() - n0); end
        else for (int i = 0; i < 3; i++) begin
            if (i > 0) checks++;
            if (lv[n0+i] !== ev[i] || lc[n0+i] - t0 != et[i]) begin
                errors++; $display("FAIL b2b[%0d] got %h@%0d want %h@%0d", i, lv[n0+i], lc[n0+i] - t0, ev[i], et[i]);
            end
        end
        cfg_wr(0, 0); idle(10);
    endtask

    task automatic test_period_change;
        logic [5:0] ev[3] = '{6'h01, 6'h02, 6'h04};
        int et[3] = '{1, 8, 11};
        cfg_wr(1, 10); cfg_wr(2, 1);
        n0 = lv.size();
        cfg_wr(0, 3); t0 = cyc;
        idle(5);
        cfg_wr(1, 3);
        wait_writes(n0 + 3);
        checks++;
        if (lv.size() < n0 + 3) begin errors++; $display("FAIL per_timeout got %0d want 3 writes", lv.size() - n0); end
        else for (int i = 0; i < 3; i++) begin
            if (i > 0) checks++;
            if (lv[n0+i] !== ev[i] || lc[n0+i] - t0 != et[i]) begin
                errors++; $display("FAIL per[%0d] got %h@%0d want %h@%0d", i, lv[n0+i], lc[n0+i] - t0, ev[i], et[i]);
            end
        end
        cfg_wr(0, 0); idle(10);
    endtask

    task automatic test_disable_reset;
        cfg_wr(1, 4); cfg_wr(2, 0);
        n0 = lv.size();
        cfg_wr(0, 7);
        idle(2);
        cfg_wr(0, 0);
        idle(20);
        checks++; if (lv.size() - n0 != 1) begin errors++; $display("FAIL disable_writes got %0d want 1", lv.size() - n0); end
        cfg_wr(3, 32'h2A);
        reset = 1;
        @(negedge clk);
        checks++; if (pio_chipselect !== 1'b1) begin errors++; $display("FAIL inflight_cs got %b want 1", pio_chipselect); end
        idle(1);
        cfg_address = 3; @(negedge clk);
        checks++; if (pio_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs got %b want 0", pio_chipselect); end
        checks++; if (pio_write_n !== 1'b1) begin errors++; $display("FAIL rst_wn got %b want 1", pio_write_n); end
        checks++; if (pio_writedata !== 32'd0) begin errors++; $display("FAIL rst_wd got %h want 0", pio_writedata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (cfg_readdata !== 32'd0) begin errors++; $display("FAIL rst_cur got %h want 0", cfg_readdata); end
        idle(1); reset = 0;
        idle(20);
        checks++; if (lv.size() - n0 != 2) begin errors++; $display("FAIL post_reset_writes got %0d want 2", lv.size() - n0); end
        checks++; if (b2b !== 1'b0) begin errors++; $display("FAIL cs_back_to_back got %b want 0", b2b); end
    endtask

    initial begin
        test_reset;
        test_walk;
        test_blink;
        test_count_wrap;
        test_direct_at_tc;
        test_direct_restart;
        test_back_to_back;
        test_period_change;
        test_disable_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
